// File: rtl/hb_pkg.sv
// Shared definitions for the boot sequencer: FSM state encoding and per-byte cycle counts.
package hb_pkg;

  localparam int unsigned DEFAULT_ADDR_W      = 12;
  localparam int unsigned COPY_CYC_PER_BYTE   = 3;
  localparam int unsigned VERIFY_CYC_PER_BYTE = 2;
  localparam int unsigned SETTLE_W            = 8;

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_RD,
    ST_WR,
    ST_NXT,
    ST_VRD,
    ST_VCMP,
    ST_DONE,
    ST_FAIL
  } boot_state_e;

endpackage

// File: rtl/boot_addr_counter.sv
// Copy/verify address counter with synchronous clear, increment enable and a registered
// terminal flag that is high while count == WORDS-1.
module boot_addr_counter
  import hb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned WORDS  = 4096
) (
  input  logic              clk,
  input  logic              rst_bar,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(WORDS - 1);
  localparam logic              LAST_AT_ZERO = (LAST_ADDR == '0);

  logic [ADDR_W-1:0] count_inc_c;

  assign count_inc_c = count + ADDR_W'(1);

  // The flag tracks the value being loaded so it is valid in the same cycle as count.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      count <= '0;
      last  <= LAST_AT_ZERO;
    end else if (clear) begin
      count <= '0;
      last  <= LAST_AT_ZERO;
    end else if (inc) begin
      count <= count_inc_c;
      last  <= (count_inc_c == LAST_ADDR);
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// Power-on EEPROM-to-RAM copy sequencer that releases the CPU with boot_done.
// Define BOOT_VERIFY_EN to add a RAM read-back verify pass (VRD/VCMP/FAIL).
module boot_sequencer
  import hb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned WORDS      = 4096,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_bar,
  input  logic              boot_req,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_ce_bar,
  input  logic [7:0]        rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce_bar,
  output logic              ram_we_bar,
  output logic              ram_data_oe,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              busy,
  output logic              boot_done,
  output logic              error,
  output logic [ADDR_W-1:0] fail_addr
);

  if (WORDS < 1 || longint'(WORDS) > (longint'(1) << ADDR_W)) begin : g_bad_words
    $error("boot_sequencer: WORDS out of range 1..2**ADDR_W");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("boot_sequencer: SETTLE_CYC out of range 1..255");
  end

  boot_state_e         state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [ADDR_W-1:0]   addr;
  logic                cnt_last;
  logic                cnt_clear_c;
  logic                cnt_inc_c;

  boot_addr_counter #(
    .ADDR_W (ADDR_W),
    .WORDS  (WORDS)
  ) u_addr_counter (
    .clk     (clk),
    .rst_bar (rst_bar),
    .clear   (cnt_clear_c),
    .inc     (cnt_inc_c),
    .count   (addr),
    .last    (cnt_last)
  );

  assign rom_addr = addr;
  assign ram_addr = addr;

`ifdef BOOT_VERIFY_EN
  logic [7:0] rom_q;
  logic [7:0] ram_q;
  logic       match_c;

  assign match_c = (rom_q == ram_q);
`else
  logic unused_rdata;

  assign unused_rdata = ^ram_rdata;
  assign error        = 1'b0;
  assign fail_addr    = '0;
`endif

  // Counter control; the terminal byte never increments, so a full 2**ADDR_W image cannot wrap.
  always_comb begin
    cnt_clear_c = 1'b0;
    cnt_inc_c   = 1'b0;
    case (state)
      ST_NXT: begin
        cnt_inc_c = !cnt_last;
`ifdef BOOT_VERIFY_EN
        cnt_clear_c = cnt_last;
`endif
      end
`ifdef BOOT_VERIFY_EN
      ST_VCMP: cnt_inc_c   = match_c && !cnt_last;
      ST_FAIL: cnt_clear_c = boot_req;
`endif
      ST_DONE: cnt_clear_c = boot_req;
      default: ;
    endcase
  end

  // FSM with outputs registered for the state being entered.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state       <= ST_SETTLE;
      settle_cnt  <= '0;
      rom_ce_bar  <= 1'b1;
      ram_ce_bar  <= 1'b1;
      ram_we_bar  <= 1'b1;
      ram_data_oe <= 1'b0;
      ram_wdata   <= '0;
      busy        <= 1'b1;
      boot_done   <= 1'b0;
`ifdef BOOT_VERIFY_EN
      rom_q       <= '0;
      ram_q       <= '0;
      error       <= 1'b0;
      fail_addr   <= '0;
`endif
    end else begin
      case (state)
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) begin
            state      <= ST_RD;
            rom_ce_bar <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end
        ST_RD: begin
          state       <= ST_WR;
          ram_wdata   <= rom_data;
          rom_ce_bar  <= 1'b1;
          ram_ce_bar  <= 1'b0;
          ram_we_bar  <= 1'b0;
          ram_data_oe <= 1'b1;
        end
        ST_WR: begin
          state      <= ST_NXT;
          ram_we_bar <= 1'b1;
        end
        ST_NXT: begin
          ram_ce_bar  <= 1'b1;
          ram_data_oe <= 1'b0;
          if (!cnt_last) begin
            state      <= ST_RD;
            rom_ce_bar <= 1'b0;
          end else begin
`ifdef BOOT_VERIFY_EN
            state      <= ST_VRD;
            rom_ce_bar <= 1'b0;
            ram_ce_bar <= 1'b0;
`else
            state      <= ST_DONE;
            busy       <= 1'b0;
            boot_done  <= 1'b1;
`endif
          end
        end
`ifdef BOOT_VERIFY_EN
        ST_VRD: begin
          state      <= ST_VCMP;
          rom_q      <= rom_data;
          ram_q      <= ram_rdata;
          rom_ce_bar <= 1'b1;
          ram_ce_bar <= 1'b1;
        end
        ST_VCMP: begin
          if (!match_c) begin
            state     <= ST_FAIL;
            busy      <= 1'b0;
            error     <= 1'b1;
            fail_addr <= addr;
          end else if (cnt_last) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            boot_done <= 1'b1;
          end else begin
            state      <= ST_VRD;
            rom_ce_bar <= 1'b0;
            ram_ce_bar <= 1'b0;
          end
        end
        ST_FAIL: begin
          if (boot_req) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            busy       <= 1'b1;
            error      <= 1'b0;
          end
        end
`endif
        ST_DONE: begin
          if (boot_req) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            busy       <= 1'b1;
            boot_done  <= 1'b0;
          end
        end
        default: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: a small 4-byte instance driven from a vector table
// plus hand sequences, and a full 4096-byte instance for the wrap/terminal corner.
module tb_boot_sequencer;

  localparam int unsigned AW = 12;
`ifdef BOOT_VERIFY_EN
  localparam int S_DONE_EDGE = 22;
`else
  localparam int S_DONE_EDGE = 14;
`endif
  localparam int L_DONE_EDGE = 12292;
  localparam int L_LIMIT     = 30000;

  logic clk = 1'b0;
  logic rst_s = 1'b0;
  logic rst_l = 1'b0;
  logic boot_req = 1'b0;

  always #5 clk = ~clk;

  // Small instance signals
  logic [AW-1:0] s_rom_addr, s_ram_addr, s_fail_addr;
  logic          s_rom_ce_bar, s_ram_ce_bar, s_ram_we_bar, s_ram_data_oe;
  logic [7:0]    s_rom_data, s_ram_wdata, s_ram_rdata;
  logic          s_busy, s_boot_done, s_error;

  // Large instance signals
  logic [AW-1:0] l_rom_addr, l_ram_addr, l_fail_addr;
  logic          l_rom_ce_bar, l_ram_ce_bar, l_ram_we_bar, l_ram_data_oe;
  logic [7:0]    l_rom_data, l_ram_wdata, l_ram_rdata;
  logic          l_busy, l_boot_done, l_error;

  logic [7:0] rom_s [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] ram_s [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] ram_l [4096];

  int s_wr_cnt = 0;
  int s_low_run = 0;
  int s_max_low = 0;
  int l_wr_cnt = 0;
  int l_zero_wr = 0;
  logic [AW-1:0] l_last_wr = '0;

  int n_cmp = 0;
  int n_fail = 0;

  boot_sequencer #(.ADDR_W(AW), .WORDS(4), .SETTLE_CYC(2)) dut_s (
    .clk(clk), .rst_bar(rst_s), .boot_req(boot_req),
    .rom_addr(s_rom_addr), .rom_ce_bar(s_rom_ce_bar), .rom_data(s_rom_data),
    .ram_addr(s_ram_addr), .ram_ce_bar(s_ram_ce_bar), .ram_we_bar(s_ram_we_bar),
    .ram_data_oe(s_ram_data_oe), .ram_wdata(s_ram_wdata), .ram_rdata(s_ram_rdata),
    .busy(s_busy), .boot_done(s_boot_done), .error(s_error), .fail_addr(s_fail_addr)
  );

  boot_sequencer #(.ADDR_W(AW), .WORDS(4096), .SETTLE_CYC(4)) dut_l (
    .clk(clk), .rst_bar(rst_l), .boot_req(1'b0),
    .rom_addr(l_rom_addr), .rom_ce_bar(l_rom_ce_bar), .rom_data(l_rom_data),
    .ram_addr(l_ram_addr), .ram_ce_bar(l_ram_ce_bar), .ram_we_bar(l_ram_we_bar),
    .ram_data_oe(l_ram_data_oe), .ram_wdata(l_ram_wdata), .ram_rdata(l_ram_rdata),
    .busy(l_busy), .boot_done(l_boot_done), .error(l_error), .fail_addr(l_fail_addr)
  );

  // Memory models: async-read ROMs; large RAM reads back 0xFF at 0x005.
  assign s_rom_data  = rom_s[s_rom_addr[1:0]];
  assign s_ram_rdata = ram_s[s_ram_addr[1:0]];
  assign l_rom_data  = l_rom_addr[7:0];
  assign l_ram_rdata = (l_ram_addr == 12'h005) ? 8'hFF : ram_l[l_ram_addr];

  always @(negedge clk) begin
    if (!s_ram_we_bar && !s_ram_ce_bar && s_ram_data_oe) begin
      ram_s[s_ram_addr[1:0]] <= s_ram_wdata;
      s_wr_cnt <= s_wr_cnt + 1;
    end
    if (!s_ram_we_bar) begin
      s_low_run <= s_low_run + 1;
      if (s_low_run + 1 > s_max_low) s_max_low <= s_low_run + 1;
    end else begin
      s_low_run <= 0;
    end
  end

  always @(negedge clk) begin
    if (!l_ram_we_bar && !l_ram_ce_bar && l_ram_data_oe) begin
      ram_l[l_ram_addr] <= l_ram_wdata;
      l_wr_cnt  <= l_wr_cnt + 1;
      l_last_wr <= l_ram_addr;
      if (l_ram_addr == '0) l_zero_wr <= l_zero_wr + 1;
    end
  end

  typedef struct {
    int         edge_n;
    logic [5:0] ctl;    // {boot_done, busy, rom_ce_bar, ram_ce_bar, ram_we_bar, ram_data_oe}
    logic [11:0] addr;
    logic [7:0] wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [37:0] s_outs();
    return {s_boot_done, s_busy, s_rom_ce_bar, s_ram_ce_bar, s_ram_we_bar, s_ram_data_oe,
            s_rom_addr, s_ram_addr, s_ram_wdata};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_small_ram(input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_ram%0d", tag, i), 64'(ram_s[i]), 64'(rom_s[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int w0;
    int le;
    logic [37:0] exp_v;
    logic [37:0] rst_v;

    rst_v = {6'b011110, 12'h000, 12'h000, 8'h00};

    vecs.push_back('{0,  6'b011110, 12'h000, 8'h00});
    vecs.push_back('{1,  6'b011110, 12'h000, 8'h00});
    vecs.push_back('{2,  6'b010110, 12'h000, 8'h00});
    vecs.push_back('{3,  6'b011001, 12'h000, 8'h11});
    vecs.push_back('{4,  6'b011011, 12'h000, 8'h11});
    vecs.push_back('{5,  6'b010110, 12'h001, 8'h11});
    vecs.push_back('{6,  6'b011001, 12'h001, 8'h22});
    vecs.push_back('{8,  6'b010110, 12'h002, 8'h22});
    vecs.push_back('{9,  6'b011001, 12'h002, 8'h33});
    vecs.push_back('{12, 6'b011001, 12'h003, 8'h44});
    vecs.push_back('{13, 6'b011011, 12'h003, 8'h44});
`ifdef BOOT_VERIFY_EN
    vecs.push_back('{14, 6'b010010, 12'h000, 8'h44});
    vecs.push_back('{15, 6'b011110, 12'h000, 8'h44});
    vecs.push_back('{21, 6'b011110, 12'h003, 8'h44});
    vecs.push_back('{22, 6'b101110, 12'h003, 8'h44});
`else
    vecs.push_back('{14, 6'b101110, 12'h003, 8'h44});
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'(s_outs()), 64'(rst_v));
    chk("rst_err", 64'({s_error, s_fail_addr}), 64'(0));
    @(negedge clk);
    rst_s = 1'b1;

    // Table-driven copy of the 4-byte image
    cur = 0;
    foreach (vecs[i]) begin
      while (cur < vecs[i].edge_n) begin
        tick();
        cur++;
      end
      exp_v = {vecs[i].ctl, vecs[i].addr, vecs[i].addr, vecs[i].wdata};
      chk($sformatf("edge%0d", vecs[i].edge_n), 64'(s_outs()), 64'(exp_v));
    end
    check_small_ram("copy1");
    chk("copy1_strobes", 64'(s_wr_cnt), 64'(4));
    chk("strobe_width", 64'(s_max_low), 64'(1));
    chk("copy1_err", 64'({s_error, s_fail_addr}), 64'(0));

    // boot_req in DONE restarts; a pulse mid-copy is ignored
    w0 = s_wr_cnt;
    boot_req = 1'b1;
    tick();
    boot_req = 1'b0;
    chk("req_accept", 64'({s_boot_done, s_busy, s_ram_addr}), 64'({1'b0, 1'b1, 12'h000}));
    for (int k = 1; k <= S_DONE_EDGE; k++) begin
      boot_req = (k == 6);
      tick();
      if (k == 6) chk("req_ignored_busy", 64'({s_boot_done, s_busy}), 64'({1'b0, 1'b1}));
      if (k == S_DONE_EDGE - 1) chk("rerun_done_early", 64'(s_boot_done), 64'(0));
      if (k == S_DONE_EDGE) chk("rerun_done", 64'(s_boot_done), 64'(1));
    end
    boot_req = 1'b0;
    chk("rerun_strobes", 64'(s_wr_cnt - w0), 64'(4));

    // Asynchronous reset during WR of byte 2
    boot_req = 1'b1;
    tick();
    boot_req = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    chk("pre_rst_wr", 64'({s_ram_we_bar, s_ram_addr}), 64'({1'b1 ^ 1'b1, 12'h002}));
    rst_s = 1'b0;
    #1;
    chk("midrst_outs", 64'(s_outs()), 64'(rst_v));
    chk("midrst_err", 64'({s_error, s_fail_addr}), 64'(0));
    @(negedge clk);
    rst_s = 1'b1;
    w0 = s_wr_cnt;
    for (int k = 1; k <= S_DONE_EDGE; k++) begin
      tick();
      if (k == S_DONE_EDGE - 1) chk("postrst_done_early", 64'(s_boot_done), 64'(0));
      if (k == S_DONE_EDGE) chk("postrst_done", 64'(s_boot_done), 64'(1));
    end
    chk("postrst_strobes", 64'(s_wr_cnt - w0), 64'(4));
    check_small_ram("postrst");

    // Full 4096-byte image on the large instance
    @(negedge clk);
    rst_l = 1'b1;
    le = 0;
    while (l_busy && le < L_LIMIT) begin
      tick();
      le++;
    end
    chk("l_finished", 64'(l_busy), 64'(0));
`ifdef BOOT_VERIFY_EN
    chk("l_error", 64'(l_error), 64'(1));
    chk("l_fail_addr", 64'(l_fail_addr), 64'(12'h005));
    chk("l_boot_done", 64'(l_boot_done), 64'(0));
`else
    chk("l_done_edge", 64'(le), 64'(L_DONE_EDGE));
    chk("l_boot_done", 64'(l_boot_done), 64'(1));
    chk("l_err", 64'({l_error, l_fail_addr}), 64'(0));
`endif
    chk("l_last_wr", 64'(l_last_wr), 64'(12'hFFF));
    chk("l_zero_wr", 64'(l_zero_wr), 64'(1));
    chk("l_wr_cnt", 64'(l_wr_cnt), 64'(4096));
    chk("l_ram_fff", 64'(ram_l[12'hFFF]), 64'(8'hFF));
    chk("l_ram_005", 64'(ram_l[12'h005]), 64'(8'h05));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
